gcd_engine: RTL and testbench
=============================

Name: gcd_engine

Overview:
Sequential greatest-common-divisor engine. It consumes the X<Y comparison result, which is the downstream end of the comparator interface, and drives subtract-and-swap iterations until the operands converge. It takes two unsigned operands with a start/done handshake and returns the GCD plus a zero-operand flag. It sits between the operand input logic (switches/registers) and the result display in the GCD design.

Parameters:
WIDTH, 4, operand and result width in bits (unsigned)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a computation; sampled only in IDLE
x_in  input  WIDTH  operand X; captured on the start edge
y_in  input  WIDTH  operand Y; captured on the start edge
busy  output  1  high from the capture edge until the edge that raises done
done  output  1  one-cycle pulse: gcd_out/zero_op valid from this cycle
gcd_out  output  WIDTH  result; held until the next completed computation
zero_op  output  1  set with done when either captured operand was 0; held with gcd_out

Behaviour:
- Reset: rst_n=0 asynchronously forces state=IDLE and xr=yr=0. It also sets busy=0, done=0, gcd_out=0 and zero_op=0. This applies mid-computation too; the run is abandoned and no done is produced.
- States: IDLE, CALC, DONE (encoded per the shared defs).
- IDLE: start=1 at edge E0 → xr<=x_in, yr<=y_in, busy<=1, state<=CALC. start=0 → remain IDLE.
- CALC: exactly one action per cycle, evaluated in this priority order:
  1. xr==yr → gcd_out<=xr, zero_op<=(xr==0), state<=DONE.
  2. xr==0 or yr==0 → gcd_out<=xr|yr, zero_op<=1, state<=DONE.
  3. x_lt_y (xr<yr) → yr<=yr-xr.
  4. otherwise (xr>yr) → xr<=xr-yr.
- Entering DONE: done<=1 and busy<=0 on the same edge.
- DONE: lasts one cycle. done<=0, state<=IDLE. start in DONE is ignored.
- Latency: with S = number of subtractions, done rises at edge E0+S+1. Worst case for WIDTH=4 is (15,1) or (1,15): S=14, done at E0+15.
- Arithmetic: subtraction is performed only when the minuend is strictly greater. It never underflows and stays WIDTH bits; no carry is kept.
- start asserted while busy or in DONE: ignored. It is neither queued nor restarted.
- start held high continuously: a new capture occurs in each IDLE cycle, giving back-to-back runs separated by one IDLE cycle.
- x_in/y_in changes after the capture edge: no effect on the run in progress.
- gcd_out/zero_op change only on the edge that enters DONE.

Decomposition:
- Shared header gcd_defs.vh holds:
  - state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2)
  - default WIDTH constant
- One natural sub-module: gcd_datapath.
  - Contents: xr/yr registers, WIDTH-bit subtractor, equality/zero detect, and the X<Y comparator output x_lt_y.
  - It exports the status bits eq, x_zero, y_zero and x_lt_y to the FSM in gcd_engine.
  - The FSM drives load/sub_x/sub_y enables into it.
  - Neither the FSM nor the datapath exceeds ~150 lines.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, start=0 for 5 cycles → busy=0, done=0, gcd_out=0, zero_op=0 throughout.
- Basic: start pulse with x=12, y=8 at E0 → registers go (4,8) then (4,4). done pulses at E0+3 with gcd_out=4, zero_op=0; busy is high E0..E0+2.
- Worst case and symmetry:
  - x=15, y=1 → done at E0+15, gcd_out=1.
  - x=1, y=15 → same timing and result.
  - x=9, y=6 → gcd_out=3 at E0+3.
- Zero and equal operands:
  - x=0, y=9 → done at E0+1, gcd_out=9, zero_op=1.
  - x=0, y=0 → gcd_out=0, zero_op=1.
  - x=7, y=7 → done at E0+1, gcd_out=7, zero_op=0.
- Handshake abuse:
  - start re-pulsed mid-run with new x/y → ignored; the original result is returned.
  - start held high → consecutive runs, each done followed by one IDLE cycle then busy.
  - x_in changed after E0 → no effect.
- Async reset mid-run: start x=15, y=1, assert rst_n low at E0+5 between edges → all outputs 0 immediately. No done is produced; the next start with x=10, y=4 completes with gcd_out=2.

Source files
------------

// File: rtl/gcd_engine_pkg.sv
// Shared definitions for the GCD engine: FSM state encoding and default operand width.
package gcd_engine_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers for the GCD engine with a single shared subtractor and the
// status detectors (equality, zero, X<Y) that steer the controlling FSM.
module gcd_datapath
    import gcd_engine_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_sub_x,
    input  logic             i_sub_y,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_xr,
    output logic [WIDTH-1:0] o_yr,
    output logic             o_eq,
    output logic             o_x_zero,
    output logic             o_y_zero,
    output logic             o_x_lt_y
);

    logic [WIDTH-1:0] r_xr;
    logic [WIDTH-1:0] r_yr;
    logic             w_x_lt_y;
    logic [WIDTH-1:0] w_minuend;
    logic [WIDTH-1:0] w_subtrahend;
    logic [WIDTH-1:0] w_diff;

    // One subtractor serves both directions: the larger operand is always the
    // minuend, so the result never wraps and no carry is needed.
    assign w_x_lt_y     = (r_xr < r_yr);
    assign w_minuend    = w_x_lt_y ? r_yr : r_xr;
    assign w_subtrahend = w_x_lt_y ? r_xr : r_yr;
    assign w_diff       = w_minuend - w_subtrahend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xr <= '0;
            r_yr <= '0;
        end else if (i_load) begin
            r_xr <= i_x;
            r_yr <= i_y;
        end else if (i_sub_x) begin
            r_xr <= w_diff;
        end else if (i_sub_y) begin
            r_yr <= w_diff;
        end
    end

    assign o_xr     = r_xr;
    assign o_yr     = r_yr;
    assign o_eq     = (r_xr == r_yr);
    assign o_x_zero = (r_xr == '0);
    assign o_y_zero = (r_yr == '0);
    assign o_x_lt_y = w_x_lt_y;

endmodule

// File: rtl/gcd_engine.sv
// Sequential subtract-and-swap GCD engine: start/done handshake around the
// gcd_datapath, with the result and zero-operand flag held until the next run.
module gcd_engine
    import gcd_engine_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             zero_op
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_gcd;
    logic             r_zero_op;

    logic             w_load;
    logic             w_sub_x;
    logic             w_sub_y;
    logic             w_finish_eq;
    logic             w_finish_zero;

    logic [WIDTH-1:0] w_xr;
    logic [WIDTH-1:0] w_yr;
    logic             w_eq;
    logic             w_x_zero;
    logic             w_y_zero;
    logic             w_x_lt_y;

    gcd_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_sub_x  (w_sub_x),
        .i_sub_y  (w_sub_y),
        .i_x      (x_in),
        .i_y      (y_in),
        .o_xr     (w_xr),
        .o_yr     (w_yr),
        .o_eq     (w_eq),
        .o_x_zero (w_x_zero),
        .o_y_zero (w_y_zero),
        .o_x_lt_y (w_x_lt_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = CALC;
            CALC:    if (w_eq || w_x_zero || w_y_zero) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Equality outranks the zero check so (0,0) is reported via the equal path
    // with its zero flag still set; only one datapath action fires per cycle.
    always_comb begin
        w_load        = 1'b0;
        w_sub_x       = 1'b0;
        w_sub_y       = 1'b0;
        w_finish_eq   = 1'b0;
        w_finish_zero = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = start;
            end
            CALC: begin
                busy = 1'b1;
                if (w_eq) begin
                    w_finish_eq = 1'b1;
                end else if (w_x_zero || w_y_zero) begin
                    w_finish_zero = 1'b1;
                end else if (w_x_lt_y) begin
                    w_sub_y = 1'b1;
                end else begin
                    w_sub_x = 1'b1;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gcd     <= '0;
            r_zero_op <= 1'b0;
        end else if (w_finish_eq) begin
            r_gcd     <= w_xr;
            r_zero_op <= w_x_zero;
        end else if (w_finish_zero) begin
            r_gcd     <= w_xr | w_yr;
            r_zero_op <= 1'b1;
        end
    end

    assign gcd_out = r_gcd;
    assign zero_op = r_zero_op;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: a Euclid-based reference model checked every
// cycle, plus directed runs with hand-computed results and latencies.
module tb_gcd_engine;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] gcd_out;
    logic         zero_op;

    int checks = 0;
    int failures = 0;
    bit checkEn = 1'b0;

    // reference model state
    bit mBusy = 1'b0;
    bit mDone = 1'b0;
    int mGcd = 0;
    bit mZero = 1'b0;
    int mLeft = 0;
    int pGcd = 0;
    bit pZero = 1'b0;

    gcd_engine #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .x_in    (x_in),
        .y_in    (y_in),
        .busy    (busy),
        .done    (done),
        .gcd_out (gcd_out),
        .zero_op (zero_op)
    );

    always #5 clk = ~clk;

    // Result via Euclid's remainder algorithm; subtraction count is the sum of
    // the quotients minus one (the final subtraction is replaced by equality).
    function automatic void refGcd(input int x, input int y, output int g, output int s, output bit z);
        int a, b, t;
        s = 0;
        if (x == 0 || y == 0) begin
            g = x | y;
            z = 1'b1;
        end else begin
            a = x;
            b = y;
            while (b != 0) begin
                s = s + a / b;
                t = a % b;
                a = b;
                b = t;
            end
            g = a;
            s = s - 1;
            z = 1'b0;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g, s;
        bit z;
        if (!rst_n) begin
            mBusy = 1'b0;
            mDone = 1'b0;
            mGcd  = 0;
            mZero = 1'b0;
            mLeft = 0;
        end else if (mDone) begin
            mDone = 1'b0;
        end else if (mBusy) begin
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
                mBusy = 1'b0;
                mDone = 1'b1;
                mGcd  = pGcd;
                mZero = pZero;
            end
        end else if (start) begin
            refGcd(int'(x_in), int'(y_in), g, s, z);
            pGcd  = g;
            pZero = z;
            mLeft = s + 1;
            mBusy = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_busy", int'(busy), int'(mBusy));
            checkOutput("model_done", int'(done), int'(mDone));
            checkOutput("model_gcd", int'(gcd_out), mGcd);
            checkOutput("model_zero", int'(zero_op), int'(mZero));
        end
    end

    // Pulse start for one edge, disturb the operands afterwards, and time done.
    task automatic applyStimulus(input int x, input int y, input int expGcd, input int expZero, input int expEdges);
        int n;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        x_in  = W'(x);
        y_in  = W'(y);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        x_in  = ~W'(x);
        y_in  = W'(y + 5);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput($sformatf("timeout_%0d_%0d", x, y), 0, 1);
        end else begin
            checkOutput($sformatf("latency_%0d_%0d", x, y), n, expEdges);
            checkOutput($sformatf("gcd_%0d_%0d", x, y), int'(gcd_out), expGcd);
            checkOutput($sformatf("zero_%0d_%0d", x, y), int'(zero_op), expZero);
        end
        @(negedge clk);
        checkOutput("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        int n;
        int doneCount;
        bit seen;

        #1 rst_n = 1'b0;
        #1 checkEn = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("idle_outputs", int'({busy, done, gcd_out, zero_op}), 0);
        end

        applyStimulus(12, 8, 4, 0, 3);
        applyStimulus(15, 1, 1, 0, 15);
        applyStimulus(1, 15, 1, 0, 15);
        applyStimulus(9, 6, 3, 0, 3);
        applyStimulus(0, 9, 9, 1, 1);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(7, 7, 7, 0, 1);

        // start re-pulsed mid-run with new operands must be ignored
        @(negedge clk);
        start = 1'b1; x_in = 4'd12; y_in = 4'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; x_in = 4'd15; y_in = 4'd1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("restart_latency", n, 3);
        checkOutput("restart_gcd", int'(gcd_out), 4);
        repeat (3) @(negedge clk);

        // start held high: dones at E0+3 and E0+8 within ten edges
        start = 1'b1; x_in = 4'd9; y_in = 4'd6;
        @(posedge clk);
        doneCount = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (done) doneCount++;
        end
        start = 1'b0;
        checkOutput("held_start_dones", doneCount, 2);
        repeat (20) @(negedge clk);

        // asynchronous reset mid-run abandons the computation
        start = 1'b1; x_in = 4'd15; y_in = 4'd1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_outputs", int'({busy, done, gcd_out, zero_op}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("no_done_after_reset", doneCount, 0);
        applyStimulus(10, 4, 2, 0, 4);

        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "[TB] global timeout");
    end

endmodule
